// File: rtl/function_plotter_pkg.sv
// Shared symbol codes, PS/2 prefix bytes and decoder state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package function_plotter_pkg;

    localparam int ASCII_W = 7;

    localparam logic [ASCII_W-1:0] SYMBOL_NONE      = 7'd0;
    localparam logic [ASCII_W-1:0] SYMBOL_LEFT      = 7'd1;
    localparam logic [ASCII_W-1:0] SYMBOL_RIGHT     = 7'd2;
    localparam logic [ASCII_W-1:0] SYMBOL_BACKSPACE = 7'd3;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT  = 8'h12;
    localparam logic [7:0] CODE_RSHIFT  = 8'h59;
    localparam logic [7:0] CODE_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_EXT_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BREAK,
        ST_EXT_BREAK
    } kbd_state_t;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == CODE_LSHIFT) || (code == CODE_RSHIFT);
    endfunction

endpackage

// File: rtl/scancode_lut.sv
// Set-2 make code to symbol map, with optional shifted variants.
// Latency: combinational.
// Backpressure: none; pure lookup.
module scancode_lut
    import function_plotter_pkg::*;
(
    input  logic [7:0]         code,
    input  logic               shift,
    output logic [ASCII_W-1:0] symbol,
    output logic               valid
);

    always_comb begin
        symbol = SYMBOL_NONE;
        valid  = 1'b1;
        case (code)
            8'h66: symbol = SYMBOL_BACKSPACE;
            8'h16: symbol = 7'h31;
            8'h1E: symbol = 7'h32;
            8'h26: symbol = 7'h33;
            8'h25: symbol = 7'h34;
            8'h2E: symbol = 7'h35;
            8'h36: symbol = 7'h36;
            8'h3D: symbol = 7'h37;
            8'h3E: symbol = 7'h38;
            8'h46: symbol = 7'h39;
            8'h45: symbol = 7'h30;
            8'h1C: symbol = 7'h61;
            8'h32: symbol = 7'h62;
            8'h21: symbol = 7'h63;
            8'h23: symbol = 7'h64;
            8'h24: symbol = 7'h65;
            8'h2B: symbol = 7'h66;
            8'h34: symbol = 7'h67;
            8'h33: symbol = 7'h68;
            8'h43: symbol = 7'h69;
            8'h3B: symbol = 7'h6A;
            8'h42: symbol = 7'h6B;
            8'h4B: symbol = 7'h6C;
            8'h3A: symbol = 7'h6D;
            8'h31: symbol = 7'h6E;
            8'h44: symbol = 7'h6F;
            8'h4D: symbol = 7'h70;
            8'h15: symbol = 7'h71;
            8'h2D: symbol = 7'h72;
            8'h1B: symbol = 7'h73;
            8'h2C: symbol = 7'h74;
            8'h3C: symbol = 7'h75;
            8'h2A: symbol = 7'h76;
            8'h1D: symbol = 7'h77;
            8'h22: symbol = 7'h78;
            8'h35: symbol = 7'h79;
            8'h1A: symbol = 7'h7A;
            8'h4E: symbol = 7'h2D;
            8'h55: symbol = 7'h3D;
            8'h49: symbol = 7'h2E;
            8'h4A: symbol = 7'h2F;
            8'h79: symbol = 7'h2B;
            8'h7C: symbol = 7'h2A;
            8'h29: symbol = 7'h20;
            default: valid = 1'b0;
        endcase

        // Keypad 79/7C are not listed here, so they keep their unshifted glyph.
        if (shift && valid) begin
            if (symbol >= 7'h61 && symbol <= 7'h7A) begin
                symbol = symbol - 7'h20;
            end else begin
                case (code)
                    8'h3E: symbol = 7'h2A;
                    8'h55: symbol = 7'h2B;
                    8'h46: symbol = 7'h28;
                    8'h45: symbol = 7'h29;
                    8'h36: symbol = 7'h5E;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 byte stream to one-cycle symbol pulses; shift tracking under KEYBOARD_DECODER_SHIFT_EN.
// Latency: symbol registered, one cycle after the completing scancode_valid strobe.
// Backpressure: none; every strobe is consumed, output is a fire-and-forget pulse.
module keyboard_decoder
    import function_plotter_pkg::*;
#(
    parameter int SYMBOL_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              scancode,
    input  logic                    scancode_valid,
    output logic [SYMBOL_WIDTH-1:0] keyboard_symbol
);

    kbd_state_t         state;
    logic               lut_shift;
    logic [ASCII_W-1:0] lut_symbol;
    logic               lut_valid;

`ifdef KEYBOARD_DECODER_SHIFT_EN
    logic shift_q;
    assign lut_shift = shift_q;
`else
    assign lut_shift = 1'b0;
`endif

    scancode_lut u_lut (
        .code   (scancode),
        .shift  (lut_shift),
        .symbol (lut_symbol),
        .valid  (lut_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            keyboard_symbol <= '0;
`ifdef KEYBOARD_DECODER_SHIFT_EN
            shift_q         <= 1'b0;
`endif
        end else begin
            keyboard_symbol <= '0;
            if (scancode_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (scancode == PREFIX_EXT) begin
                            state <= ST_EXT;
                        end else if (scancode == PREFIX_BREAK) begin
                            state <= ST_BREAK;
`ifdef KEYBOARD_DECODER_SHIFT_EN
                        end else if (is_shift_code(scancode)) begin
                            shift_q <= 1'b1;
`endif
                        end else if (lut_valid) begin
                            keyboard_symbol <= SYMBOL_WIDTH'(lut_symbol);
                        end
                    end
                    ST_EXT: begin
                        if (scancode == PREFIX_BREAK) begin
                            state <= ST_EXT_BREAK;
                        end else begin
                            state <= ST_IDLE;
                            if (scancode == CODE_EXT_LEFT) begin
                                keyboard_symbol <= SYMBOL_WIDTH'(SYMBOL_LEFT);
                            end else if (scancode == CODE_EXT_RIGHT) begin
                                keyboard_symbol <= SYMBOL_WIDTH'(SYMBOL_RIGHT);
                            end
                        end
                    end
                    ST_BREAK: begin
                        state <= ST_IDLE;
`ifdef KEYBOARD_DECODER_SHIFT_EN
                        if (is_shift_code(scancode)) begin
                            shift_q <= 1'b0;
                        end
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Directed vector bench for keyboard_decoder; expectations follow KEYBOARD_DECODER_SHIFT_EN.
module tb_keyboard_decoder;

`ifdef KEYBOARD_DECODER_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic [6:0] keyboard_symbol;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] code;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    keyboard_decoder #(.SYMBOL_WIDTH(7)) dut (
        .clk             (clk),
        .rst             (rst),
        .scancode        (scancode),
        .scancode_valid  (scancode_valid),
        .keyboard_symbol (keyboard_symbol)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] code, input logic [6:0] exp, input string name);
        vec_t v;
        v.code = code;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    // One strobe, check the pulse one cycle later, then check it has dropped.
    task automatic send(input logic [7:0] code, input logic [6:0] exp, input string name);
        scancode       = code;
        scancode_valid = 1'b1;
        @(negedge clk);
        scancode_valid = 1'b0;
        check(name, keyboard_symbol, exp);
        @(negedge clk);
        check({name, "_drop"}, keyboard_symbol, 7'h00);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        check("rst_pulse_out", keyboard_symbol, 7'h00);
        rst = 1'b0;
    endtask

    initial begin
        add(8'h16, 7'h31, "make_1");
        add(8'hE0, 7'h00, "ext_prefix_a");
        add(8'h6B, 7'h01, "ext_left");
        add(8'hE0, 7'h00, "ext_prefix_b");
        add(8'h74, 7'h02, "ext_right");
        add(8'hE0, 7'h00, "extbrk_e0");
        add(8'hF0, 7'h00, "extbrk_f0");
        add(8'h6B, 7'h00, "extbrk_6b");
        add(8'h1C, 7'h61, "make_a");
        add(8'hF0, 7'h00, "brk_a_f0");
        add(8'h1C, 7'h00, "brk_a_1c");
        add(8'h12, 7'h00, "lshift_make");
        add(8'h1C, SH ? 7'h41 : 7'h61, "shift_a");
        add(8'hF0, 7'h00, "lshift_brk_f0");
        add(8'h12, 7'h00, "lshift_brk_12");
        add(8'h1C, 7'h61, "unshift_a");
        add(8'h66, 7'h03, "backspace");
        add(8'h12, 7'h00, "lshift_make2");
        add(8'h3E, SH ? 7'h2A : 7'h38, "shift_8");
        add(8'h7C, 7'h2A, "shift_kp_star");
        add(8'h79, 7'h2B, "shift_kp_plus");
        add(8'h46, SH ? 7'h28 : 7'h39, "shift_9");
        add(8'hF0, 7'h00, "lshift_brk2_f0");
        add(8'h12, 7'h00, "lshift_brk2_12");
        add(8'h59, 7'h00, "rshift_make");
        add(8'h15, SH ? 7'h51 : 7'h71, "rshift_q");
        add(8'h55, SH ? 7'h2B : 7'h3D, "rshift_eq");
        add(8'hF0, 7'h00, "rshift_brk_f0");
        add(8'h59, 7'h00, "rshift_brk_59");
        add(8'h15, 7'h71, "unshift_q");
        add(8'hAA, 7'h00, "bat_ok");
        add(8'hFA, 7'h00, "ack");
        add(8'h0D, 7'h00, "unmapped_0d");
        add(8'h00, 7'h00, "zero_byte");
        add(8'h79, 7'h2B, "kp_plus");
        add(8'h7C, 7'h2A, "kp_star");
        add(8'h4E, 7'h2D, "minus");
        add(8'h29, 7'h20, "space");
        add(8'h4D, 7'h70, "make_p");
        add(8'h1A, 7'h7A, "make_z");
        add(8'h45, 7'h30, "make_0");
        add(8'h4A, 7'h2F, "slash");
        add(8'h49, 7'h2E, "dot");

        // A break prefix strobed during reset must not survive it.
        rst            = 1'b1;
        scancode       = 8'hF0;
        scancode_valid = 1'b1;
        @(negedge clk);
        check("reset_out", keyboard_symbol, 7'h00);
        @(negedge clk);
        check("reset_out_hold", keyboard_symbol, 7'h00);
        rst            = 1'b0;
        scancode_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle", keyboard_symbol, 7'h00);
        send(8'h16, 7'h31, "strobe_in_reset_discarded");

        foreach (vecs[i]) begin
            send(vecs[i].code, vecs[i].exp, vecs[i].name);
        end

        // Typematic repeat on back-to-back strobes.
        scancode       = 8'h1C;
        scancode_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("typematic", keyboard_symbol, 7'h61);
        end
        scancode_valid = 1'b0;
        @(negedge clk);
        check("typematic_drop", keyboard_symbol, 7'h00);

        // State holds across idle cycles.
        send(8'hE0, 7'h00, "hold_e0");
        repeat (4) @(negedge clk);
        check("hold_idle", keyboard_symbol, 7'h00);
        send(8'h74, 7'h02, "hold_right");

        // Reset abandons partial sequences.
        send(8'hF0, 7'h00, "rst_brk_f0");
        pulse_rst();
        send(8'h16, 7'h31, "rst_brk_then_1");
        send(8'hE0, 7'h00, "rst_ext_e0");
        pulse_rst();
        send(8'h74, 7'h00, "rst_ext_then_74");
        send(8'hE0, 7'h00, "rst_eb_e0");
        send(8'hF0, 7'h00, "rst_eb_f0");
        pulse_rst();
        send(8'h1C, 7'h61, "rst_eb_then_a");
        send(8'h12, 7'h00, "rst_shift_12");
        pulse_rst();
        send(8'h1C, 7'h61, "rst_clears_shift");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keyboard_decoder.md
KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 7: width of the emitted symbol code.
REQ-002 SHALL have port clk  input  1  the system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port scancode  input  8  one PS/2 set-2 scan-code byte from the PS/2 receiver.
REQ-005 SHALL have port scancode_valid  input  1  one-cycle strobe; scancode is valid while it is high.
REQ-006 SHALL have port keyboard_symbol  output  SYMBOL_WIDTH  one-cycle symbol pulse to logic_; 0 means no symbol.

Function
REQ-007 SHALL encode symbols as 0 none, 1 left arrow, 2 right arrow, 3 backspace, otherwise 7-bit ASCII.
REQ-008 SHALL use an FSM with states IDLE, EXT (after E0), BREAK (after F0) and EXT_BREAK (after E0 F0).
REQ-009 SHALL advance state only on cycles with scancode_valid=1; otherwise hold state and drive keyboard_symbol=0.
REQ-010 IDLE transitions: E0->EXT; F0->BREAK; a mapped make code->emit symbol, stay IDLE; any other byte->ignore, stay IDLE.
REQ-011 EXT transitions: 6B->emit 1; 74->emit 2; F0->EXT_BREAK; any other byte->ignore. Every case except F0 returns to IDLE.
REQ-012 BREAK transitions: any byte completes the break, emits nothing and returns to IDLE. Byte 12 or 59 also clears shift.
REQ-013 EXT_BREAK transitions: any byte emits nothing and returns to IDLE.
REQ-014 Make codes 12 (left shift) and 59 (right shift) in IDLE SHALL set shift and emit nothing.
REQ-015 Unshifted map: 66->3; 16,1E,26,25,2E,36,3D,3E,46,45->'1'..'9','0'; set-2 letter codes->'a'..'z'; 4E->'-'; 55->'='; 49->'.'; 4A->'/'; 79->'+'; 7C->'*'; 29->' '.
REQ-016 Keypad codes 79 and 7C SHALL map the same way regardless of shift.
REQ-017 Latency: keyboard_symbol SHALL be registered and SHALL be valid exactly one cycle after the completing scancode_valid cycle.
REQ-018 keyboard_symbol SHALL be nonzero for exactly one cycle per emitted symbol and 0 on all other cycles.
REQ-019 Typematic repeats (repeated make codes without a break) SHALL each emit a symbol.
REQ-020 Bytes AA (BAT OK), FA (ACK) and 00 received in IDLE SHALL be ignored.

Reset
REQ-021 While rst=1: state=IDLE, shift=0, keyboard_symbol=0. Any scancode_valid on that cycle SHALL be discarded.
REQ-022 Reset asserted mid-sequence (in EXT, BREAK or EXT_BREAK) SHALL abandon the partial sequence without emitting a symbol.

Configuration
REQ-023 Macro KEYBOARD_DECODER_SHIFT_EN SHALL control shift support.
REQ-024 With KEYBOARD_DECODER_SHIFT_EN defined: shift is tracked. Shifted map: letters->'A'..'Z'; 3E->'*'; 55->'+'; 46->'('; 45->')'; 36->'^'. Unlisted shifted keys use the unshifted map.
REQ-025 Without KEYBOARD_DECODER_SHIFT_EN: no shift register. Codes 12 and 59 are ignored and only the unshifted map applies.

Structure
REQ-026 Package function_plotter_pkg SHALL hold the SYMBOL_NONE/LEFT/RIGHT/BACKSPACE constants and the E0/F0 prefix constants. logic_ SHALL use the same constants.
REQ-027 SHALL instantiate one combinational sub-module, scancode_lut (inputs: code, shift; outputs: symbol, valid). The FSM and output register stay in keyboard_decoder.

Verification
REQ-028 Bytes 16 -> keyboard_symbol=0x31 ('1') for one cycle, exactly one cycle after the strobe.
REQ-029 Bytes E0,6B -> 1. Bytes E0,74 -> 2. Bytes E0,F0,6B -> nothing.
REQ-030 Bytes 1C, F0,1C -> 0x61 ('a') once. The break emits nothing.
REQ-031 With SHIFT_EN: bytes 12,1C,F0,12,1C -> 0x41 then 0x61. Without SHIFT_EN: the same bytes -> 0x61, 0x61.
REQ-032 Bytes 66 -> 3. Bytes 12,3E with SHIFT_EN -> 0x2A ('*'). Bytes AA, FA, 0D -> nothing.
REQ-033 Bytes F0, then rst pulse, then 16 -> 0x31 emitted; the pending break is discarded.
